prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter D, default 12, instruction-memory address width; matches the program counter width.
REQ-002 Parameter W, default 9, machine-code word width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a load; sampled only in IDLE or DONE.
REQ-006 len  input  D  number of words to load, sampled on the accepted start; 0 is legal.
REQ-007 in_valid  input  1  source has a word on in_data.
REQ-008 in_data  input  W  machine-code word.
REQ-009 in_ready  output  1  loader accepts in_data this cycle.
REQ-010 wr_en  output  1  instruction-memory write strobe.
REQ-011 wr_addr  output  D  instruction-memory write address.
REQ-012 wr_data  output  W  instruction-memory write data.
REQ-013 core_reset  output  1  holds the processor core (PC and flags) in reset while high.
REQ-014 load_done  output  1  program loaded and core released.
REQ-015 err  output  1  sticky protocol-error flag.

Function
REQ-016 The block SHALL implement states IDLE, LOAD, FLUSH and DONE, encoded in one registered state variable.
REQ-017 In IDLE: core_reset=1, in_ready=0, load_done=0.
REQ-018 Accepted start in IDLE or DONE: SHALL latch len, clear the word counter cnt to 0, and go to LOAD if len!=0, or FLUSH if len==0.
REQ-019 In LOAD: in_ready=1 combinationally; all other states: in_ready=0.
REQ-020 Beat: in_valid && in_ready in the same cycle; only beats advance cnt.
REQ-021 A beat at edge t SHALL register wr_en=1, wr_addr=cnt, wr_data=in_data, visible for exactly the cycle after t.
REQ-022 When no beat occurs, wr_en SHALL be 0 on the next cycle; wr_addr and wr_data hold their last values.
REQ-023 cnt SHALL increment by 1 per beat, modulo 2^D.
REQ-024 The beat with cnt==len-1 SHALL move LOAD->FLUSH; no further beats are accepted.
REQ-025 FLUSH SHALL last exactly one cycle, covering the final wr_en pulse, then go to DONE.
REQ-026 In DONE: core_reset=0, load_done=1; the state persists until start or reset.
REQ-027 core_reset SHALL be 1 in IDLE, LOAD and FLUSH, and registered so it falls on the edge entering DONE.
REQ-028 start during LOAD or FLUSH SHALL be ignored and SHALL set err=1.
REQ-029 start in DONE SHALL restart the load: core_reset=1 and load_done=0 on the next cycle; the core is held for the entire reload.
REQ-030 in_valid outside LOAD SHALL be ignored: no write, no error.
REQ-031 len=2^D-1 (max) SHALL write addresses 0..2^D-2; cnt never wraps within one load.
REQ-032 err SHALL clear only on reset.

Reset
REQ-033 Reset SHALL force asynchronously: state=IDLE, cnt=0, wr_en=0, wr_addr=0, wr_data=0, core_reset=1, load_done=0, err=0.
REQ-034 Reset mid-LOAD SHALL abandon the load, with no wr_en pulse after assertion; a new start is required.
REQ-035 After reset release, the first accepted start SHALL be no earlier than the first rising edge with reset low.

Verification
REQ-036 Reset, start with len=3, in_valid held high with words 0x1A1,0x0F2,0x133 -> writes at addr 0,1,2 on three consecutive cycles; FLUSH one cycle; core_reset falls and load_done rises the next cycle.
REQ-037 len=4 with in_valid toggled 1,0,1,0,1,0,1 -> exactly 4 wr_en pulses at addr 0..3 with correct data; no pulse follows an idle cycle.
REQ-038 len=0 -> no wr_en; DONE reached 2 cycles after start; err=0.
REQ-039 start pulsed during LOAD of len=5 -> load completes normally with 5 writes; err=1 and stays 1 through DONE and until reset.
REQ-040 reset asserted asynchronously after 2 of 6 beats -> outputs return to reset values immediately; restart with len=2 -> writes to addr 0,1.
REQ-041 DONE then start with len=1 -> core_reset=1 next cycle; one write to addr 0; back to DONE with core_reset=0.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: streams machine code into instruction memory and holds
// the core in reset until the whole program has been written.
module prog_loader #(
   parameter int D = 12,
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [D-1:0] len,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         wr_en,
   output logic [D-1:0] wr_addr,
   output logic [W-1:0] wr_data,
   output logic         core_reset,
   output logic         load_done,
   output logic         err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [D-1:0] ONE = {{(D-1){1'b0}}, 1'b1};

   logic [1:0]   state_q, state_d;
   logic [D-1:0] len_q, len_d;
   logic [D-1:0] cnt_q, cnt_d;
   logic         wr_en_q, wr_en_d;
   logic [D-1:0] wr_addr_q, wr_addr_d;
   logic [W-1:0] wr_data_q, wr_data_d;
   logic         core_reset_q, core_reset_d;
   logic         load_done_q, load_done_d;
   logic         err_q, err_d;

   logic beat;
   logic last_beat;

   assign in_ready  = (state_q == S_LOAD);
   assign beat      = in_valid & in_ready;
   assign last_beat = beat & (cnt_q == (len_q - ONE));

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign core_reset = core_reset_q;
   assign load_done  = load_done_q;
   assign err        = err_q;

   // Next-state: load sequencing, write-port capture and error tracking
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      err_d     = err_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               len_d   = len;
               cnt_d   = '0;
               state_d = (len != '0) ? S_LOAD : S_FLUSH;
            end
         end
         S_LOAD: begin
            if (start) begin
               err_d = 1'b1;
            end
            if (beat) begin
               wr_en_d   = 1'b1;
               wr_addr_d = cnt_q;
               wr_data_d = in_data;
               cnt_d     = cnt_q + ONE;
               if (last_beat) begin
                  state_d = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            if (start) begin
               err_d = 1'b1;
            end
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      // Core is released only while sitting in DONE
      core_reset_d = (state_d != S_DONE);
      load_done_d  = (state_d == S_DONE);
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         len_q        <= '0;
         cnt_q        <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         core_reset_q <= 1'b1;
         load_done_q  <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         core_reset_q <= core_reset_d;
         load_done_q  <= load_done_d;
         err_q        <= err_d;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table-driven and randomized checks of prog_loader
// against a transaction-level reference model.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [11:0] len;
   logic        in_valid;
   logic [8:0]  in_data;
   logic        in_ready;
   logic        wr_en;
   logic [11:0] wr_addr;
   logic [8:0]  wr_data;
   logic        core_reset;
   logic        load_done;
   logic        err;

   int total = 0;
   int bad   = 0;

   prog_loader #(.D(12), .W(9)) dut (
      .clk       (clk),
      .reset     (rst),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .core_reset(core_reset),
      .load_done (load_done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // reference model: words still owed, next address, phase flags
   int          m_left;
   bit          m_load, m_flush, m_done, m_err, m_we;
   logic [11:0] m_addr, m_next;
   logic [8:0]  m_data;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   task automatic mreset();
      m_left  = 0;
      m_load  = 0;
      m_flush = 0;
      m_done  = 0;
      m_err   = 0;
      m_we    = 0;
      m_addr  = '0;
      m_next  = '0;
      m_data  = '0;
   endtask

   task automatic mupdate();
      m_we = 0;
      if (m_flush) begin
         if (start) m_err = 1;
         m_flush = 0;
         m_done  = 1;
      end else if (m_load) begin
         if (start) m_err = 1;
         if (in_valid) begin
            m_we   = 1;
            m_addr = m_next;
            m_data = in_data;
            m_next = m_next + 12'd1;
            m_left--;
            if (m_left == 0) begin
               m_load  = 0;
               m_flush = 1;
            end
         end
      end else if (start) begin
         m_done = 0;
         m_next = '0;
         m_left = int'(len);
         if (len == 12'd0) m_flush = 1;
         else m_load = 1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) mreset();
      else mupdate();
      #1;
      chk("in_ready", in_ready, m_load);
      chk("wr_en", wr_en, m_we);
      chk("wr_addr", wr_addr, m_addr);
      chk("wr_data", wr_data, m_data);
      chk("core_reset", core_reset, !m_done);
      chk("load_done", load_done, m_done);
      chk("err", err, m_err);
   endtask

   task automatic run_load(input int L, input logic [15:0] vm,
                           output int nwr, output int edges);
      nwr      = 0;
      start    = 1;
      len      = L[11:0];
      in_valid = 1;
      in_data  = 9'($urandom);
      step();
      if (wr_en) nwr++;
      start = 0;
      edges = 1;
      for (int j = 0; j < 4 * L + 40; j++) begin
         in_valid = vm[j % 16];
         in_data  = 9'($urandom);
         step();
         edges++;
         if (wr_en) nwr++;
         if (load_done) break;
      end
      chk("reached_done", load_done, 1);
      in_valid = 1;
      for (int k = 0; k < 2; k++) begin
         in_data = 9'($urandom);
         step();
         if (wr_en) nwr++;
      end
   endtask

   typedef struct {
      int          len;
      logic [15:0] vmask;
      int          wr;
      int          edges;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int nwr;
      int edges;
      int L;

      tbl[0] = '{3, 16'hFFFF, 3, 5};
      tbl[1] = '{4, 16'h0055, 4, 9};
      tbl[2] = '{0, 16'hFFFF, 0, 2};
      tbl[3] = '{1, 16'h0004, 1, 5};
      tbl[4] = '{2, 16'h0006, 2, 5};
      tbl[5] = '{5, 16'hFFFF, 5, 7};

      mreset();
      rst      = 1;
      start    = 0;
      len      = '0;
      in_valid = 0;
      in_data  = '0;
      step();
      step();
      chk("rst_core_reset", core_reset, 1);
      chk("rst_load_done", load_done, 0);
      chk("rst_wr_en", wr_en, 0);
      rst = 0;
      step();

      // table: loads back to back, each later one restarts from DONE
      foreach (tbl[i]) begin
         run_load(tbl[i].len, tbl[i].vmask, nwr, edges);
         chk($sformatf("tbl%0d_writes", i), nwr, tbl[i].wr);
         chk($sformatf("tbl%0d_edges", i), edges, tbl[i].edges);
         chk($sformatf("tbl%0d_err", i), err, 0);
      end

      // largest length: addresses 0..4094, no wrap
      run_load(4095, 16'hFFFF, nwr, edges);
      chk("max_writes", nwr, 4095);
      chk("max_edges", edges, 4097);
      chk("max_last_addr", wr_addr, 12'hFFE);

      // start pulsed mid-load: load completes, err sticky
      nwr      = 0;
      start    = 1;
      len      = 12'd5;
      in_valid = 1;
      step();
      start = 0;
      step();
      if (wr_en) nwr++;
      step();
      if (wr_en) nwr++;
      start = 1;
      step();
      if (wr_en) nwr++;
      start = 0;
      for (int j = 0; j < 20; j++) begin
         step();
         if (wr_en) nwr++;
         if (load_done) break;
      end
      chk("errload_done", load_done, 1);
      chk("errload_writes", nwr, 5);
      chk("errload_err", err, 1);
      step();
      step();
      chk("err_sticky", err, 1);

      // async reset mid-load after 2 of 6 beats
      start    = 1;
      len      = 12'd6;
      in_valid = 1;
      step();
      start = 0;
      step();
      step();
      chk("pre_rst_wr_en", wr_en, 1);
      #2;
      rst = 1;
      #1;
      chk("async_wr_en", wr_en, 0);
      chk("async_wr_addr", wr_addr, 0);
      chk("async_wr_data", wr_data, 0);
      chk("async_core_reset", core_reset, 1);
      chk("async_err", err, 0);
      chk("async_in_ready", in_ready, 0);
      mreset();
      step();
      step();
      rst = 0;
      run_load(2, 16'hFFFF, nwr, edges);
      chk("restart_writes", nwr, 2);
      chk("restart_edges", edges, 4);

      // randomized loads with random valid and stray starts
      for (int it = 0; it < 25; it++) begin
         L        = int'($urandom_range(0, 12));
         start    = 1;
         len      = L[11:0];
         in_valid = 1'($urandom_range(0, 1));
         in_data  = 9'($urandom);
         step();
         for (int j = 0; j < 200; j++) begin
            start    = ($urandom_range(0, 15) == 0);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 9'($urandom);
            step();
            if (load_done) break;
         end
         start = 0;
         chk("rand_done", load_done, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
